// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad encoder constants, FSM states and key map (KEYPAD_ABORT_EN adds '*' abort)
package keypad_pkg;

    localparam logic [1:0] CMD_NONE   = 2'b00;
    localparam logic [1:0] CMD_ARM    = 2'b01;
    localparam logic [1:0] CMD_DISARM = 2'b10;
    localparam logic [1:0] CMD_ABORT  = 2'b11;

    localparam logic [1:0] SCAN         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] EMIT         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        KEY_IGNORE = 2'd0,
        KEY_DIGIT  = 2'd1,
        KEY_CMD    = 2'd2
    } key_kind_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] value;
    } key_t;

    // value carries the digit for KEY_DIGIT and the command code (low bits) for KEY_CMD
    function automatic key_t key_map(input logic [1:0] row, input logic [1:0] col);
        key_t k;
        k.kind  = KEY_IGNORE;
        k.value = 4'd0;
        case ({row, col})
            4'h0: k = '{KEY_DIGIT, 4'd1};
            4'h1: k = '{KEY_DIGIT, 4'd2};
            4'h2: k = '{KEY_DIGIT, 4'd3};
            4'h3: k = '{KEY_CMD, {2'b00, CMD_ARM}};
            4'h4: k = '{KEY_DIGIT, 4'd4};
            4'h5: k = '{KEY_DIGIT, 4'd5};
            4'h6: k = '{KEY_DIGIT, 4'd6};
            4'h7: k = '{KEY_CMD, {2'b00, CMD_DISARM}};
            4'h8: k = '{KEY_DIGIT, 4'd7};
            4'h9: k = '{KEY_DIGIT, 4'd8};
            4'hA: k = '{KEY_DIGIT, 4'd9};
`ifdef KEYPAD_ABORT_EN
            4'hC: k = '{KEY_CMD, {2'b00, CMD_ABORT}};
`else
            4'hC: k = '{KEY_IGNORE, 4'd0};
`endif
            4'hD: k = '{KEY_DIGIT, 4'd0};
            default: k = '{KEY_IGNORE, 4'd0};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// rtl/keypad_encoder_if.sv - command/digit interface from keypad encoder to the security FSM
interface keypad_encoder_if;
    logic [1:0] command;
    logic [3:0] digit;
    logic       input_digit;

    modport master (output command, output digit, output input_digit);
    modport slave  (input  command, input  digit, input  input_digit);
endinterface

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchroniser for asynchronous inputs
module keypad_sync #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 keypad scanner/debouncer emitting command pulses and digit strobes
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic             busy,
    keypad_encoder_if.master cmd_bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       rs;
    logic [1:0]       state;
    logic [1:0]       col;
    logic [1:0]       cap_row;
    logic [1:0]       low_row;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] rel_cnt;
    key_t             cap_key;

    keypad_sync #(
        .WIDTH    (4),
        .RESET_VAL(4'hF)
    ) u_row_sync (
        .clk  (clk),
        .reset(reset),
        .d    (row_in),
        .q    (rs)
    );

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign busy = (state != SCAN);

    // Lowest-index low row wins when several rows share the driven column.
    always_comb begin
        low_row = 2'd3;
        if (!rs[2]) low_row = 2'd2;
        if (!rs[1]) low_row = 2'd1;
        if (!rs[0]) low_row = 2'd0;
    end

    assign cap_key = key_map(cap_row, col);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt             <= '0;
            state               <= SCAN;
            col                 <= 2'd0;
            col_out             <= 4'b1110;
            cap_row             <= 2'd0;
            match_cnt           <= '0;
            rel_cnt             <= '0;
            cmd_bus.command     <= CMD_NONE;
            cmd_bus.digit       <= 4'd0;
            cmd_bus.input_digit <= 1'b0;
        end else begin
            div_cnt             <= tick ? '0 : div_cnt + 1'b1;
            cmd_bus.command     <= CMD_NONE;
            cmd_bus.input_digit <= 1'b0;
            case (state)
                SCAN: begin
                    if (tick) begin
                        if (rs != 4'hF) begin
                            cap_row   <= low_row;
                            match_cnt <= CNT_W'(1);
                            state     <= DEBOUNCE;
                        end else begin
                            col     <= col + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick) begin
                        if (!rs[cap_row]) begin
                            match_cnt <= match_cnt + 1'b1;
                            // The pulse is registered on entry so it coincides with the EMIT cycle.
                            if (match_cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                                state <= EMIT;
                                case (cap_key.kind)
                                    KEY_DIGIT: begin
                                        cmd_bus.input_digit <= 1'b1;
                                        cmd_bus.digit       <= cap_key.value;
                                    end
                                    KEY_CMD:  cmd_bus.command <= cap_key.value[1:0];
                                    default:  ;
                                endcase
                            end
                        end else begin
                            col     <= col + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                            state   <= SCAN;
                        end
                    end
                end
                EMIT: begin
                    rel_cnt <= '0;
                    state   <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (tick) begin
                        if (rs == 4'hF) begin
                            rel_cnt <= rel_cnt + 1'b1;
                            if (rel_cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
                                col     <= col + 2'd1;
                                col_out <= {col_out[2:0], col_out[3]};
                                state   <= SCAN;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - self-checking bench for keypad_encoder (honours KEYPAD_ABORT_EN)
module tb_keypad_encoder;

    localparam int SD = 4;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        busy;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    keypad_encoder_if kb ();

    keypad_encoder #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .row_in (row_in),
        .col_out(col_out),
        .busy   (busy),
        .cmd_bus(kb)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    function automatic logic [3:0] key_rows(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (k[i*4+j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign row_in = key_rows(keys, col_out);

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, got, exp, cyc, $time);
        end
    endtask

    // Reference model: phase names, integer counters, key legend as text.
    localparam int LOOK = 0, CONFIRM = 1, FIRE = 2, DRAIN = 3;
    string      keymap [4] = '{"123A", "456B", "789C", "*0#D"};
    logic [3:0] m_s1, m_s2;
    int         m_div, m_ph, m_col, m_row, m_hits, m_clear;
    int         e_cmd, e_id, e_dig;
    bit         m_valid = 1'b0;

    task automatic key_effect(input int r, input int c);
        byte ch;
        ch = keymap[r].getc(c);
        if (ch >= 8'd48 && ch <= 8'd57) begin
            e_id  = 1;
            e_dig = ch - 8'd48;
        end else if (ch == 8'd65) e_cmd = 1;
        else if (ch == 8'd66) e_cmd = 2;
`ifdef KEYPAD_ABORT_EN
        else if (ch == 8'd42) e_cmd = 3;
`endif
    endtask

    task automatic model_step();
        logic [3:0] rs;
        bit         tick;
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_div = 0; m_ph = LOOK; m_col = 0;
            m_row = 0; m_hits = 0; m_clear = 0; e_cmd = 0; e_id = 0; e_dig = 0;
            return;
        end
        tick  = (m_div == SD - 1);
        m_div = (m_div + 1) % SD;
        rs    = m_s2;
        m_s2  = m_s1;
        m_s1  = row_in;
        e_cmd = 0;
        e_id  = 0;
        if (m_ph == FIRE) begin
            m_ph = DRAIN; m_clear = 0;
        end else if (tick) begin
            if (m_ph == LOOK) begin
                if (rs != 4'hF) begin
                    m_row = 0;
                    while (rs[m_row]) m_row++;
                    m_hits = 1; m_ph = CONFIRM;
                end else m_col = (m_col + 1) % 4;
            end else if (m_ph == CONFIRM) begin
                if (!rs[m_row]) begin
                    m_hits++;
                    if (m_hits == DC) begin
                        m_ph = FIRE;
                        key_effect(m_row, m_col);
                    end
                end else begin
                    m_col = (m_col + 1) % 4; m_ph = LOOK;
                end
            end else begin
                if (rs == 4'hF) begin
                    m_clear++;
                    if (m_clear == DC) begin
                        m_col = (m_col + 1) % 4; m_ph = LOOK;
                    end
                end else m_clear = 0;
            end
        end
    endtask

    int ev_cyc[$], ev_cmd[$], ev_dig[$], ev_id[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("col_out", col_out, 4'b1111 ^ (4'b0001 << m_col));
            chk("busy", busy, (m_ph != LOOK));
            chk("command", kb.command, e_cmd);
            chk("input_digit", kb.input_digit, e_id);
            chk("digit", kb.digit, e_dig);
            chk("cmd_digit_exclusive", (kb.command != 2'b00) && kb.input_digit, 0);
        end
        if (!reset && (kb.command != 2'b00 || kb.input_digit)) begin
            ev_cyc.push_back(cyc);
            ev_cmd.push_back(kb.command);
            ev_dig.push_back(kb.digit);
            ev_id.push_back(kb.input_digit);
        end
        model_step();
        m_valid = 1'b1;
    end

    task automatic clear_events();
        ev_cyc.delete(); ev_cmd.delete(); ev_dig.delete(); ev_id.delete();
    endtask

    task automatic wait_until(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_until: cyc %0d never reached %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        keys  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_events();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col_out", col_out, 4'b1110);
        chk("rst_command", kb.command, 2'b00);
        chk("rst_input_digit", kb.input_digit, 0);
        chk("rst_digit", kb.digit, 0);
        chk("rst_busy", busy, 0);

        // Key '1': detect at tick cyc 3, strobe at cyc 12, release done at cyc 24
        do_reset();
        keys = 16'h0001;
        wait_until(11); chk("k1_pre_strobe", kb.input_digit, 0);
        wait_until(12); chk("k1_strobe", kb.input_digit, 1); chk("k1_digit", kb.digit, 1);
        keys = 16'h0000;
        wait_until(23); chk("k1_busy_hold", busy, 1);
        wait_until(24); chk("k1_busy_done", busy, 0); chk("k1_col_next", col_out, 4'b1101);
        wait_until(40);
        chk("k1_events", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) chk("k1_ev_cyc", ev_cyc[0], 12);

        // A then B
        do_reset();
        keys = 16'h0008;
        wait_until(24); chk("arm_pulse", kb.command, 2'b01);
        keys = 16'h0000;
        wait_until(36); chk("arm_released", busy, 0);
        keys = 16'h0080;
        wait_until(60); chk("disarm_pulse", kb.command, 2'b10);
        keys = 16'h0000;
        wait_until(80);
        chk("ab_events", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) begin
            chk("ab_ev0", {ev_cyc[0], ev_cmd[0], ev_id[0]}, {32'd24, 32'd1, 32'd0});
            chk("ab_ev1", {ev_cyc[1], ev_cmd[1], ev_id[1]}, {32'd60, 32'd2, 32'd0});
        end

        // Glitch on '5' for a single tick
        do_reset();
        wait_until(4); keys = 16'h0020;
        wait_until(8); chk("glitch_busy", busy, 1); keys = 16'h0000;
        wait_until(12); chk("glitch_busy_done", busy, 0); chk("glitch_col2", col_out, 4'b1011);
        wait_until(40); chk("glitch_events", ev_cyc.size(), 0);

        // Bouncy release: high, low, high, high, high
        do_reset();
        keys = 16'h0001;
        wait_until(12); chk("bounce_strobe", kb.input_digit, 1); keys = 16'h0000;
        wait_until(16); keys = 16'h0001;
        wait_until(20); keys = 16'h0000;
        wait_until(31); chk("bounce_busy_hold", busy, 1);
        wait_until(32); chk("bounce_busy_done", busy, 0);
        wait_until(50); chk("bounce_events", ev_cyc.size(), 1);

        // Reset during DEBOUNCE at match count 2
        do_reset();
        keys = 16'h0001;
        wait_until(8); chk("mid_busy", busy, 1);
        reset = 1'b1; keys = 16'h0000;
        @(posedge clk); #1;
        chk("mid_col_out", col_out, 4'b1110);
        chk("mid_command", kb.command, 0);
        chk("mid_input_digit", kb.input_digit, 0);
        chk("mid_busy_clr", busy, 0);
        reset = 1'b0;
        clear_events();
        wait_until(40); chk("mid_events", ev_cyc.size(), 0);

        // '*' key
        do_reset();
        keys = 16'h1000;
        wait_until(12);
`ifdef KEYPAD_ABORT_EN
        chk("star_cmd", kb.command, 2'b11);
`else
        chk("star_cmd", kb.command, 2'b00);
`endif
        chk("star_no_digit", kb.input_digit, 0);
        wait_until(16); chk("star_wait_release", busy, 1);
        keys = 16'h0000;
        wait_until(28); chk("star_done", busy, 0); chk("star_col_next", col_out, 4'b1101);
        wait_until(40);
`ifdef KEYPAD_ABORT_EN
        chk("star_events", ev_cyc.size(), 1);
`else
        chk("star_events", ev_cyc.size(), 0);
`endif

        // '4' and '7' together (lowest row wins), then '2' pressed while holding
        do_reset();
        keys = 16'h0110;
        wait_until(12); chk("multi_digit", kb.digit, 4);
        keys = 16'h0112;
        wait_until(16); keys = 16'h0002;
        wait_until(60);
        chk("multi_events", ev_cyc.size(), 2);
        if (ev_cyc.size() == 2) begin
            chk("multi_ev0", {ev_cyc[0], ev_dig[0]}, {32'd12, 32'd4});
            chk("multi_ev1", {ev_cyc[1], ev_dig[1]}, {32'd40, 32'd2});
        end

        // '9' held indefinitely
        do_reset();
        keys = 16'h0400;
        wait_until(20); chk("hold_strobe", kb.input_digit, 1); chk("hold_digit", kb.digit, 9);
        wait_until(100);
        chk("hold_events", ev_cyc.size(), 1);
        chk("hold_digit_kept", kb.digit, 9);
        chk("hold_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
